uart_rx_8n1: RTL and testbench

- UART receiver for 8 data bits, no parity, 1 stop bit. It is the receive counterpart to the uart_tx_8n1 transmitter.
- Runs directly on the 12 MHz hwclk and times bits with an internal counter. No derived baud clock.
- Received bytes are presented on a valid/ack holding register, so the top-level FSM can consume them at its own pace.
- Sits between the FTDI rx pin and the top-level command/echo logic.

---
 rtl/uart_pkg.sv | 28 ++
 rtl/uart_sync2.sv | 22 ++
 rtl/uart_rx_8n1.sv | 131 +++++++++++++
 tb/tb_uart_rx_8n1.sv | 415 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver state encoding, baud timing for the
// 12 MHz board clock, and the ASCII codes used by the transmit and receive sides.
package uart_pkg;

    localparam int CLKS_PER_BIT_9600_12M = 1250;

    typedef enum logic [2:0] {
        WAIT_IDLE,
        IDLE,
        START,
        DATA,
        STOP
    } rx_state_t;

    localparam logic [7:0] ASCII_0  = 8'h30;
    localparam logic [7:0] ASCII_1  = 8'h31;
    localparam logic [7:0] ASCII_2  = 8'h32;
    localparam logic [7:0] ASCII_3  = 8'h33;
    localparam logic [7:0] ASCII_4  = 8'h34;
    localparam logic [7:0] ASCII_5  = 8'h35;
    localparam logic [7:0] ASCII_6  = 8'h36;
    localparam logic [7:0] ASCII_7  = 8'h37;
    localparam logic [7:0] ASCII_8  = 8'h38;
    localparam logic [7:0] ASCII_9  = 8'h39;
    localparam logic [7:0] ASCII_LF = 8'h0A;
    localparam logic [7:0] ASCII_CR = 8'h0D;

endpackage

// File: rtl/uart_sync2.sv
// Two-flop synchronizer for an asynchronous input that idles high; both
// flops reset to 1 so a quiet line never looks like an edge after reset.
module uart_sync2 (
    input  logic hwclk,
    input  logic reset,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge hwclk) begin
        if (reset) begin
            meta <= 1'b1;
            q    <= 1'b1;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/uart_rx_8n1.sv
// 8N1 UART receiver timed directly off hwclk, presenting each good byte
// on a valid/ack holding register with framing and overrun pulses.
module uart_rx_8n1
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = CLKS_PER_BIT_9600_12M
) (
    input  logic       hwclk,
    input  logic       reset,
    input  logic       rx,
    input  logic       rx_ack,
    output logic [7:0] rx_byte,
    output logic       rx_valid,
    output logic       frame_err,
    output logic       overrun_err,
    output logic       busy
);

    localparam int HALF_BIT = CLKS_PER_BIT / 2;
    localparam int CNT_W    = $clog2(CLKS_PER_BIT);

    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(HALF_BIT - 1);
    localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);

    logic             rx_s;
    rx_state_t        state;
    logic [CNT_W-1:0] counter;
    logic [2:0]       bit_idx;
    logic [7:0]       shift;

    uart_sync2 u_sync (
        .hwclk (hwclk),
        .reset (reset),
        .d     (rx),
        .q     (rx_s)
    );

    // The ack is applied first so a byte completing on the same edge still
    // leaves rx_valid set; IDLE is re-entered at mid stop bit so a start bit
    // immediately following the stop bit is not missed.
    always_ff @(posedge hwclk) begin
        if (reset) begin
            state       <= WAIT_IDLE;
            counter     <= '0;
            bit_idx     <= 3'd0;
            shift       <= 8'h00;
            rx_byte     <= 8'h00;
            rx_valid    <= 1'b0;
            frame_err   <= 1'b0;
            overrun_err <= 1'b0;
            busy        <= 1'b1;
        end else begin
            frame_err   <= 1'b0;
            overrun_err <= 1'b0;

            if (rx_ack && rx_valid) begin
                rx_valid <= 1'b0;
            end

            case (state)
                WAIT_IDLE: begin
                    if (rx_s) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                end

                IDLE: begin
                    if (!rx_s) begin
                        state   <= START;
                        counter <= '0;
                        busy    <= 1'b1;
                    end
                end

                START: begin
                    if (counter == HALF_LAST) begin
                        if (rx_s) begin
                            state <= IDLE;
                            busy  <= 1'b0;
                        end else begin
                            state   <= DATA;
                            counter <= '0;
                            bit_idx <= 3'd0;
                        end
                    end else begin
                        counter <= counter + CNT_W'(1);
                    end
                end

                DATA: begin
                    if (counter == BIT_LAST) begin
                        shift[bit_idx] <= rx_s;
                        counter        <= '0;
                        if (bit_idx == 3'd7) begin
                            state <= STOP;
                        end else begin
                            bit_idx <= bit_idx + 3'd1;
                        end
                    end else begin
                        counter <= counter + CNT_W'(1);
                    end
                end

                STOP: begin
                    if (counter == BIT_LAST) begin
                        counter <= '0;
                        if (rx_s) begin
                            rx_byte     <= shift;
                            rx_valid    <= 1'b1;
                            overrun_err <= rx_valid && !rx_ack;
                            state       <= IDLE;
                            busy        <= 1'b0;
                        end else begin
                            frame_err <= 1'b1;
                            state     <= WAIT_IDLE;
                        end
                    end else begin
                        counter <= counter + CNT_W'(1);
                    end
                end

                default: begin
                    state <= WAIT_IDLE;
                    busy  <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_rx_8n1.sv
// Scoreboard bench for uart_rx_8n1: frames are queued as they are driven and
// popped when the receiver presents a byte; a second instance runs at 9600 baud.
module tb_uart_rx_8n1;
    import uart_pkg::*;

    localparam int CPB      = 16;
    localparam int HALF     = CPB / 2;
    localparam int LATENCY  = 2 + HALF + 9 * CPB;
    localparam int CPB_SLOW = CLKS_PER_BIT_9600_12M;
    localparam int LAT_SLOW = 2 + CPB_SLOW / 2 + 9 * CPB_SLOW;

    logic       hwclk = 1'b0;
    logic       reset = 1'b1;
    logic       rx = 1'b1;
    logic       rx_ack = 1'b0;
    logic       rx_slow = 1'b1;
    logic       rx_ack_slow = 1'b0;

    logic [7:0] rx_byte, rx_byte_slow;
    logic       rx_valid, frame_err, overrun_err, busy;
    logic       rx_valid_slow, frame_err_slow, overrun_err_slow, busy_slow;

    int         vectors = 0;
    int         miscompares = 0;
    int         cyc = 0;
    int         last_t0 = 0;
    int         fe_count = 0;
    int         ov_count = 0;
    int         t0_log[$];
    logic [7:0] exp_q[$];

    uart_rx_8n1 #(.CLKS_PER_BIT(CPB)) dut (
        .hwclk       (hwclk),
        .reset       (reset),
        .rx          (rx),
        .rx_ack      (rx_ack),
        .rx_byte     (rx_byte),
        .rx_valid    (rx_valid),
        .frame_err   (frame_err),
        .overrun_err (overrun_err),
        .busy        (busy)
    );

    uart_rx_8n1 #(.CLKS_PER_BIT(CPB_SLOW)) dut_slow (
        .hwclk       (hwclk),
        .reset       (reset),
        .rx          (rx_slow),
        .rx_ack      (rx_ack_slow),
        .rx_byte     (rx_byte_slow),
        .rx_valid    (rx_valid_slow),
        .frame_err   (frame_err_slow),
        .overrun_err (overrun_err_slow),
        .busy        (busy_slow)
    );

    always #5 hwclk = ~hwclk;

    always @(posedge hwclk) cyc <= cyc + 1;

    // Error pulses are tallied per high cycle, so a stretched pulse shows up as a count above one.
    always @(posedge hwclk) begin
        #1;
        if (frame_err === 1'b1) fe_count++;
        if (overrun_err === 1'b1) ov_count++;
    end

    task automatic drive_bit(input logic v, input int n);
        rx = v;
        repeat (n) @(negedge hwclk);
    endtask

    task automatic drive_frame(input logic [7:0] data, input logic stop, input bit push);
        if (push) exp_q.push_back(data);
        last_t0 = cyc + 1;
        t0_log.push_back(cyc + 1);
        drive_bit(1'b0, CPB);
        for (int i = 0; i < 8; i++) drive_bit(data[i], CPB);
        drive_bit(stop, CPB);
    endtask

    task automatic wait_valid(input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge hwclk);
            if (rx_valid === 1'b1) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic pulse_ack();
        rx_ack = 1'b1;
        @(negedge hwclk);
        rx_ack = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (4) @(negedge hwclk);
        vectors++;
        if ({rx_byte, rx_valid, frame_err, overrun_err, busy} !== {8'h00, 4'b0001}) begin
            miscompares++;
            $display("[TB] FAIL reset_values: got byte=%h v=%b fe=%b ov=%b busy=%b, expected 00 0 0 0 1",
                     rx_byte, rx_valid, frame_err, overrun_err, busy);
        end
        reset = 1'b0;
        repeat (4) @(negedge hwclk);
        vectors++;
        if (busy !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL reset_to_idle: busy=%b, expected 0", busy);
        end
    endtask

    task automatic test_clean_frame(input string name, input logic [7:0] data);
        bit         ok;
        logic [7:0] exp_byte;
        fork
            drive_frame(data, 1'b1, 1'b1);
            begin
                wait_valid(LATENCY + 20, ok);
                vectors++;
                if (exp_q.size() == 0) exp_byte = 8'hxx; else exp_byte = exp_q.pop_front();
                if (!ok || rx_byte !== exp_byte) begin
                    miscompares++;
                    $display("[TB] FAIL %s: rx_byte=%h rx_valid=%b, expected %h", name, rx_byte, rx_valid, exp_byte);
                end
                pulse_ack();
            end
        join
    endtask

    task automatic test_single_byte();
        bit         ok;
        logic [7:0] exp_byte;
        fork
            drive_frame(8'h55, 1'b1, 1'b1);
            begin
                wait_valid(LATENCY + 20, ok);
                vectors++;
                if (!ok || (cyc - last_t0) != LATENCY) begin
                    miscompares++;
                    $display("[TB] FAIL single_latency: rx_valid at T0+%0d, expected T0+%0d", cyc - last_t0, LATENCY);
                end
                vectors++;
                if (exp_q.size() == 0) exp_byte = 8'hxx; else exp_byte = exp_q.pop_front();
                if (rx_byte !== exp_byte) begin
                    miscompares++;
                    $display("[TB] FAIL single_byte: rx_byte=%h, expected %h", rx_byte, exp_byte);
                end
            end
        join
        vectors++;
        if (busy !== 1'b0 || rx_valid !== 1'b1) begin
            miscompares++;
            $display("[TB] FAIL single_hold: busy=%b rx_valid=%b, expected 0 1", busy, rx_valid);
        end
        rx_ack = 1'b1;
        @(negedge hwclk);
        vectors++;
        if (rx_valid !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL single_ack: rx_valid=%b, expected 0", rx_valid);
        end
        repeat (3) @(negedge hwclk);
        rx_ack = 1'b0;
        vectors++;
        if (rx_valid !== 1'b0 || rx_byte !== 8'h55) begin
            miscompares++;
            $display("[TB] FAIL idle_ack_ignored: rx_valid=%b rx_byte=%h, expected 0 55", rx_valid, rx_byte);
        end
    endtask

    task automatic test_glitch();
        fe_count = 0;
        drive_bit(1'b0, 5);
        drive_bit(1'b1, 1);
        vectors++;
        if (busy !== 1'b1) begin
            miscompares++;
            $display("[TB] FAIL glitch_start: busy=%b, expected 1", busy);
        end
        repeat (20) @(negedge hwclk);
        vectors++;
        if (busy !== 1'b0 || rx_valid !== 1'b0 || fe_count != 0) begin
            miscompares++;
            $display("[TB] FAIL glitch_reject: busy=%b rx_valid=%b frame_errs=%0d, expected 0 0 0",
                     busy, rx_valid, fe_count);
        end
    endtask

    task automatic test_frame_error();
        fe_count = 0;
        drive_frame(8'hA3, 1'b0, 1'b0);
        drive_bit(1'b0, 100);
        vectors++;
        if (fe_count != 1 || rx_valid !== 1'b0 || rx_byte !== 8'h55 || busy !== 1'b1) begin
            miscompares++;
            $display("[TB] FAIL frame_error: frame_errs=%0d rx_valid=%b rx_byte=%h busy=%b, expected 1 0 55 1",
                     fe_count, rx_valid, rx_byte, busy);
        end
        drive_bit(1'b1, 2 * CPB);
        vectors++;
        if (busy !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL frame_error_recover: busy=%b, expected 0", busy);
        end
        test_clean_frame("after_frame_error", ASCII_1);
    endtask

    task automatic test_overrun();
        bit         ok;
        logic [7:0] exp_byte;
        ov_count = 0;
        fork
            begin
                drive_frame(ASCII_0, 1'b1, 1'b1);
                drive_frame(ASCII_9, 1'b1, 1'b1);
            end
            begin
                wait_valid(LATENCY + 20, ok);
                vectors++;
                if (exp_q.size() == 0) exp_byte = 8'hxx; else exp_byte = exp_q.pop_front();
                if (!ok || rx_byte !== exp_byte) begin
                    miscompares++;
                    $display("[TB] FAIL overrun_first: rx_byte=%h, expected %h", rx_byte, exp_byte);
                end
                ok = 1'b0;
                for (int i = 0; i < 2 * LATENCY; i++) begin
                    @(negedge hwclk);
                    if (ov_count > 0) begin
                        ok = 1'b1;
                        break;
                    end
                end
                vectors++;
                if (exp_q.size() == 0) exp_byte = 8'hxx; else exp_byte = exp_q.pop_front();
                if (!ok || rx_byte !== exp_byte || rx_valid !== 1'b1) begin
                    miscompares++;
                    $display("[TB] FAIL overrun_second: rx_byte=%h rx_valid=%b, expected %h 1", rx_byte, rx_valid, exp_byte);
                end
            end
        join
        vectors++;
        if (ov_count != 1) begin
            miscompares++;
            $display("[TB] FAIL overrun_pulse: overrun cycles=%0d, expected 1", ov_count);
        end
        pulse_ack();

        ov_count = 0;
        t0_log.delete();
        fork
            begin
                drive_frame(ASCII_0, 1'b1, 1'b1);
                drive_frame(ASCII_9, 1'b1, 1'b1);
            end
            begin
                wait_valid(LATENCY + 20, ok);
                vectors++;
                if (exp_q.size() == 0) exp_byte = 8'hxx; else exp_byte = exp_q.pop_front();
                if (!ok || rx_byte !== exp_byte) begin
                    miscompares++;
                    $display("[TB] FAIL ack_load_first: rx_byte=%h, expected %h", rx_byte, exp_byte);
                end
                for (int i = 0; i < 4 * CPB && t0_log.size() < 2; i++) @(negedge hwclk);
                if (t0_log.size() >= 2) begin
                    while (cyc < t0_log[1] + LATENCY - 1) @(negedge hwclk);
                end
                rx_ack = 1'b1;
                @(negedge hwclk);
                rx_ack = 1'b0;
                vectors++;
                if (exp_q.size() == 0) exp_byte = 8'hxx; else exp_byte = exp_q.pop_front();
                if (rx_byte !== exp_byte || rx_valid !== 1'b1) begin
                    miscompares++;
                    $display("[TB] FAIL ack_load_second: rx_byte=%h rx_valid=%b, expected %h 1", rx_byte, rx_valid, exp_byte);
                end
            end
        join
        vectors++;
        if (ov_count != 0) begin
            miscompares++;
            $display("[TB] FAIL ack_load_no_overrun: overrun cycles=%0d, expected 0", ov_count);
        end
        pulse_ack();
    endtask

    task automatic test_ascii_stream();
        bit         ok;
        logic [7:0] exp_byte;
        logic [7:0] seq [12] = '{ASCII_0, ASCII_1, ASCII_2, ASCII_3, ASCII_4, ASCII_5,
                                 ASCII_6, ASCII_7, ASCII_8, ASCII_9, ASCII_LF, ASCII_CR};
        fe_count = 0;
        ov_count = 0;
        fork
            for (int i = 0; i < 12; i++) drive_frame(seq[i], 1'b1, 1'b1);
            for (int k = 0; k < 12; k++) begin
                wait_valid(LATENCY + 2 * CPB, ok);
                vectors++;
                if (exp_q.size() == 0) exp_byte = 8'hxx; else exp_byte = exp_q.pop_front();
                if (!ok || rx_byte !== exp_byte) begin
                    miscompares++;
                    $display("[TB] FAIL stream_byte%0d: rx_byte=%h rx_valid=%b, expected %h", k, rx_byte, rx_valid, exp_byte);
                end
                pulse_ack();
            end
        join
        vectors++;
        if (fe_count != 0 || ov_count != 0 || exp_q.size() != 0) begin
            miscompares++;
            $display("[TB] FAIL stream_clean: frame_errs=%0d overruns=%0d pending=%0d, expected 0 0 0",
                     fe_count, ov_count, exp_q.size());
        end
    endtask

    task automatic test_slow_baud();
        bit         ok;
        int         t0;
        logic [7:0] data = ASCII_7;
        logic [7:0] exp_byte;
        fork
            begin
                exp_q.push_back(data);
                t0 = cyc + 1;
                rx_slow = 1'b0;
                repeat (CPB_SLOW) @(negedge hwclk);
                for (int i = 0; i < 8; i++) begin
                    rx_slow = data[i];
                    repeat (CPB_SLOW) @(negedge hwclk);
                end
                rx_slow = 1'b1;
                repeat (CPB_SLOW) @(negedge hwclk);
            end
            begin
                ok = 1'b0;
                for (int i = 0; i < LAT_SLOW + 100; i++) begin
                    @(negedge hwclk);
                    if (rx_valid_slow === 1'b1) begin
                        ok = 1'b1;
                        break;
                    end
                end
                vectors++;
                if (!ok || (cyc - t0) != LAT_SLOW) begin
                    miscompares++;
                    $display("[TB] FAIL slow_latency: rx_valid at T0+%0d, expected T0+%0d", cyc - t0, LAT_SLOW);
                end
                vectors++;
                if (exp_q.size() == 0) exp_byte = 8'hxx; else exp_byte = exp_q.pop_front();
                if (rx_byte_slow !== exp_byte || frame_err_slow !== 1'b0) begin
                    miscompares++;
                    $display("[TB] FAIL slow_byte: rx_byte=%h, expected %h", rx_byte_slow, exp_byte);
                end
                rx_ack_slow = 1'b1;
                @(negedge hwclk);
                rx_ack_slow = 1'b0;
            end
        join
    endtask

    task automatic test_reset_mid_frame();
        drive_bit(1'b0, CPB);
        drive_bit(1'b1, 4 * CPB + HALF);
        vectors++;
        if (busy !== 1'b1) begin
            miscompares++;
            $display("[TB] FAIL midframe_busy: busy=%b, expected 1", busy);
        end
        reset = 1'b1;
        rx = 1'b0;
        repeat (3) @(negedge hwclk);
        vectors++;
        if ({rx_byte, rx_valid, frame_err, overrun_err, busy} !== {8'h00, 4'b0001}) begin
            miscompares++;
            $display("[TB] FAIL midframe_reset_values: got byte=%h v=%b fe=%b ov=%b busy=%b, expected 00 0 0 0 1",
                     rx_byte, rx_valid, frame_err, overrun_err, busy);
        end
        reset = 1'b0;
        repeat (200) @(negedge hwclk);
        vectors++;
        if (rx_valid !== 1'b0 || rx_byte !== 8'h00) begin
            miscompares++;
            $display("[TB] FAIL held_low_no_decode: rx_valid=%b rx_byte=%h, expected 0 00", rx_valid, rx_byte);
        end
        drive_bit(1'b1, 2 * CPB);
        vectors++;
        if (busy !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL midframe_recover: busy=%b, expected 0", busy);
        end
        test_clean_frame("after_reset", ASCII_CR);
    endtask

    initial begin
        #3000000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        test_reset();
        test_single_byte();
        test_glitch();
        test_frame_error();
        test_overrun();
        test_ascii_stream();
        test_slow_baud();
        test_reset_mid_frame();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
